// File: rtl/tone_order_sched_pkg.sv
// Shared widths, FSM state encoding and helpers
// for the tone-ordered carrier request sequencer.
package tone_order_sched_pkg;

  localparam int DW    = 8;
  localparam int CNUMW = 8;
  localparam int IW    = 8;
  localparam int BMAX  = 15;
  localparam int BW    = 4;
  localparam int FBW   = 16;
  localparam int AW    = 24;
  // accumulator bit count never exceeds BMAX-1+DW = 22
  localparam int CW    = 5;
  // fast-path byte counter width (FastBits >> 3)
  localparam int FRW   = FBW - 3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_EMIT,
    S_DONE
  } state_t;

  // Mask keeping the n low bits of a bit group.
  function automatic logic [BMAX-1:0] low_mask(
    input logic [BW-1:0] n
  );
    return ~({BMAX{1'b1}} << n);
  endfunction

endpackage

// File: rtl/tone_order_sched_bit_accum.sv
// Bit accumulator: bytes are appended above the
// bits already held, groups are extracted from the LSB.
module tone_order_sched_bit_accum
  import tone_order_sched_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            i_clear,
  input  logic            i_push,
  input  logic [DW-1:0]   i_byte,
  input  logic            i_pop,
  input  logic [BW-1:0]   i_n,
  output logic [CW-1:0]   o_cnt,
  output logic [BMAX-1:0] o_bits
);

  logic [AW-1:0] r_acc;
  logic [CW-1:0] r_cnt;

  // Append a byte or drop the n oldest bits; a push
  // and a pop never coincide (FILL vs EMIT).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (i_clear) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (i_push) begin
      r_acc <= r_acc | (AW'(i_byte) << r_cnt);
      r_cnt <= r_cnt + CW'(DW);
    end else if (i_pop) begin
      r_acc <= r_acc >> i_n;
      r_cnt <= r_cnt - CW'(i_n);
    end
  end

  assign o_cnt  = r_cnt;
  assign o_bits = r_acc[BMAX-1:0] & low_mask(i_n);

endmodule

// File: rtl/tone_order_sched.sv
// Per-symbol sequencer walking the tone-order tables
// and issuing one (carrier, bit group) request per carrier.
module tone_order_sched
  import tone_order_sched_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  output logic             busy_o,
  output logic             done_o,
  input  logic [IW:0]      used_c_i,
  input  logic [FBW-1:0]   fast_bits_i,
  output logic [IW-1:0]    tbl_idx_o,
  input  logic [BW-1:0]    bit_load_i,
  input  logic [CNUMW-1:0] carrier_num_i,
  input  logic             fast_valid_i,
  input  logic [DW-1:0]    fast_data_i,
  output logic             fast_ready_o,
  input  logic             inter_valid_i,
  input  logic [DW-1:0]    inter_data_i,
  output logic             inter_ready_o,
  output logic             req_valid_o,
  input  logic             req_ready_i,
  output logic [CNUMW-1:0] carrier_num_o,
  output logic [BMAX-1:0]  bits_o,
  output logic [BW-1:0]    nbits_o
);

  state_t         r_state;
  logic [IW:0]    r_used;
  logic [FRW-1:0] r_fast_rem;
  logic [IW-1:0]  r_idx;
  logic           r_busy;
  logic           r_done;

  logic [CW-1:0]   w_cnt;
  logic [BMAX-1:0] w_bits;
  logic            w_need;
  logic            w_fast_sel;
  logic            w_fast_rdy;
  logic            w_inter_rdy;
  logic            w_xfer;
  logic [DW-1:0]   w_byte;
  logic            w_emit;
  logic            w_take;
  logic            w_clear;
  logic            w_last;
  logic            w_unused_fb;

  // byte granularity: the low three FastBits are dropped
  assign w_unused_fb = ^fast_bits_i[2:0];

  assign w_need = (r_state == S_FILL) &&
                  ({1'b0, bit_load_i} > w_cnt);
  assign w_fast_sel  = (r_fast_rem != '0);
  assign w_fast_rdy  = w_need & w_fast_sel;
  assign w_inter_rdy = w_need & ~w_fast_sel;
  assign w_xfer = (w_fast_rdy & fast_valid_i) |
                  (w_inter_rdy & inter_valid_i);
  assign w_byte = w_fast_sel ? fast_data_i
                             : inter_data_i;

  assign w_emit  = (r_state == S_EMIT);
  assign w_take  = w_emit & req_ready_i;
  assign w_clear = (r_state == S_IDLE) & start_i;
  assign w_last  = ({1'b0, r_idx} ==
                    r_used - {{IW{1'b0}}, 1'b1});

  tone_order_sched_bit_accum u_accum (
    .clk     (clk),
    .reset   (reset),
    .i_clear (w_clear),
    .i_push  (w_xfer),
    .i_byte  (w_byte),
    .i_pop   (w_take),
    .i_n     (bit_load_i),
    .o_cnt   (w_cnt),
    .o_bits  (w_bits)
  );

  // Symbol sequencing: fetch until the carrier's bits
  // are present, emit, advance; pulse done at the end.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_used     <= '0;
      r_fast_rem <= '0;
      r_idx      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_done) r_busy <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_used     <= used_c_i;
            r_fast_rem <= fast_bits_i[FBW-1:3];
            r_idx      <= '0;
            r_busy     <= 1'b1;
            r_state    <= (used_c_i == '0) ? S_DONE
                                           : S_FILL;
          end
        end
        S_FILL: begin
          if (!w_need)
            r_state <= S_EMIT;
          else if (w_xfer && w_fast_sel)
            r_fast_rem <= r_fast_rem -
                          {{(FRW-1){1'b0}}, 1'b1};
        end
        S_EMIT: begin
          if (req_ready_i) begin
            if (w_last) begin
              r_state <= S_DONE;
            end else begin
              r_idx   <= r_idx + {{(IW-1){1'b0}}, 1'b1};
              r_state <= S_FILL;
            end
          end
        end
        S_DONE: begin
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy_o        = r_busy;
  assign done_o        = r_done;
  assign tbl_idx_o     = r_idx;
  assign fast_ready_o  = w_fast_rdy;
  assign inter_ready_o = w_inter_rdy;
  assign req_valid_o   = w_emit;
  assign carrier_num_o = w_emit ? carrier_num_i : '0;
  assign nbits_o       = w_emit ? bit_load_i : '0;
  assign bits_o        = w_emit ? w_bits : '0;

endmodule

// File: tb/tb_tone_order_sched.sv
// Self-checking bench for tone_order_sched: directed
// scenarios plus randomized symbols vs a bit-stream model.
module tb_tone_order_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_i;
  logic        busy_o;
  logic        done_o;
  logic [8:0]  used_c_i;
  logic [15:0] fast_bits_i;
  logic [7:0]  tbl_idx_o;
  logic [3:0]  bit_load_i;
  logic [7:0]  carrier_num_i;
  logic        fast_valid_i;
  logic [7:0]  fast_data_i;
  logic        fast_ready_o;
  logic        inter_valid_i;
  logic [7:0]  inter_data_i;
  logic        inter_ready_o;
  logic        req_valid_o;
  logic        req_ready_i;
  logic [7:0]  carrier_num_o;
  logic [14:0] bits_o;
  logic [3:0]  nbits_o;

  int checks = 0;
  int errors = 0;

  logic [3:0] bl_tab [256];
  logic [7:0] cn_tab [256];
  logic [7:0] f_mem  [256];
  logic [7:0] i_mem  [256];
  int  f_pops = 0;
  int  i_pops = 0;
  int  f_lim  = 0;
  int  i_lim  = 0;
  bit  f_en   = 1'b1;
  bit  i_en   = 1'b1;

  logic [7:0]  rq_cn   [512];
  logic [3:0]  rq_nb   [512];
  logic [14:0] rq_bits [512];
  int rq_n   = 0;
  int done_n = 0;

  logic [7:0]  e_cn   [512];
  logic [3:0]  e_nb   [512];
  logic [14:0] e_bits [512];
  int e_n, e_fp, e_ip;
  int f_base, i_base, rq_base, dn_base;

  always #5 clk = ~clk;

  tone_order_sched dut (
    .clk           (clk),
    .reset         (reset),
    .start_i       (start_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .used_c_i      (used_c_i),
    .fast_bits_i   (fast_bits_i),
    .tbl_idx_o     (tbl_idx_o),
    .bit_load_i    (bit_load_i),
    .carrier_num_i (carrier_num_i),
    .fast_valid_i  (fast_valid_i),
    .fast_data_i   (fast_data_i),
    .fast_ready_o  (fast_ready_o),
    .inter_valid_i (inter_valid_i),
    .inter_data_i  (inter_data_i),
    .inter_ready_o (inter_ready_o),
    .req_valid_o   (req_valid_o),
    .req_ready_i   (req_ready_i),
    .carrier_num_o (carrier_num_o),
    .bits_o        (bits_o),
    .nbits_o       (nbits_o)
  );

  assign bit_load_i    = bl_tab[tbl_idx_o];
  assign carrier_num_i = cn_tab[tbl_idx_o];
  assign fast_valid_i  = f_en && (f_pops < f_lim);
  assign fast_data_i   = f_mem[f_pops % 256];
  assign inter_valid_i = i_en && (i_pops < i_lim);
  assign inter_data_i  = i_mem[i_pops % 256];

  // FIFO pops, request log and done pulses
  always @(posedge clk) begin
    if (fast_ready_o && fast_valid_i) f_pops <= f_pops + 1;
    if (inter_ready_o && inter_valid_i) i_pops <= i_pops + 1;
    if (req_valid_o && req_ready_i) begin
      rq_cn[rq_n % 512]   <= carrier_num_o;
      rq_nb[rq_n % 512]   <= nbits_o;
      rq_bits[rq_n % 512] <= bits_o;
      rq_n <= rq_n + 1;
    end
    if (done_o) done_n <= done_n + 1;
  end

  // Load the byte sources and derive the expected
  // requests from the concatenated LSB-first bit stream.
  task automatic prep(input int n, input int fbytes,
                      input int ffix, input int ifix);
    int total, need, ib, pos, p, bi;
    logic [7:0] b;
    total = 0;
    for (int k = 0; k < n; k++) total += int'(bl_tab[k]);
    need = (total + 7) / 8;
    f_base = f_pops; i_base = i_pops;
    rq_base = rq_n; dn_base = done_n;
    e_fp = (fbytes < need) ? fbytes : need;
    e_ip = need - e_fp;
    ib = e_ip + 2;
    for (int k = 0; k < fbytes; k++)
      f_mem[(f_base + k) % 256] =
        (ffix >= 0) ? ffix[7:0] : 8'($urandom);
    for (int k = 0; k < ib; k++)
      i_mem[(i_base + k) % 256] =
        (ifix >= 0) ? ifix[7:0] : 8'($urandom);
    f_lim = f_base + fbytes;
    i_lim = i_base + ib;
    e_n = n;
    pos = 0;
    for (int k = 0; k < n; k++) begin
      e_cn[k] = cn_tab[k];
      e_nb[k] = bl_tab[k];
      e_bits[k] = '0;
      for (int j = 0; j < int'(bl_tab[k]); j++) begin
        p = pos + j;
        bi = p / 8;
        b = (bi < fbytes) ? f_mem[(f_base + bi) % 256]
                          : i_mem[(i_base + bi - fbytes) % 256];
        e_bits[k][j] = b[p % 8];
      end
      pos += int'(bl_tab[k]);
    end
  endtask

  // Drive a symbol until done_o is seen; no checking here.
  task automatic run_sym(input bit do_start,
                         input bit rnd_rdy,
                         output int cyc, output bit tmo);
    cyc = 0;
    tmo = 1'b1;
    if (do_start) begin
      @(negedge clk); start_i = 1'b1;
      @(negedge clk); start_i = 1'b0;
      cyc = 1;
    end
    for (int c = 0; c < 3000; c++) begin
      if (done_o) begin
        tmo = 1'b0;
        break;
      end
      req_ready_i = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      cyc++;
    end
    req_ready_i = 1'b1;
  endtask

  task automatic cfg1();
    for (int k = 0; k < 4; k++) begin
      bl_tab[k] = 4'(k + 2);
      cn_tab[k] = 8'(48 + k);
    end
    used_c_i = 9'd4;
    fast_bits_i = 16'd8;
  endtask

  task automatic test_reset();
    logic [46:0] o;
    @(negedge clk);
    o = {busy_o, done_o, req_valid_o, fast_ready_o,
         inter_ready_o, tbl_idx_o, bits_o, nbits_o,
         carrier_num_o, 6'd0};
    checks++;
    if (o !== '0) begin
      errors++;
      $display("FAIL reset_outputs got %h want 0", o);
    end
    reset = 1'b0;
    @(negedge clk);
    o = {busy_o, done_o, req_valid_o, fast_ready_o,
         inter_ready_o, tbl_idx_o, bits_o, nbits_o,
         carrier_num_o, 6'd0};
    checks++;
    if (o !== '0) begin
      errors++;
      $display("FAIL idle_outputs got %h want 0", o);
    end
  endtask

  task automatic test_basic();
    int cyc;
    bit tmo;
    cfg1();
    prep(4, 1, 'hA5, 'h3C);
    run_sym(1'b1, 1'b0, cyc, tmo);
    checks++;
    if (tmo) begin
      errors++;
      $display("FAIL basic_timeout got no done want done");
    end
    checks++;
    if (busy_o !== 1'b1) begin
      errors++;
      $display("FAIL basic_busy_at_done got %b want 1", busy_o);
    end
    @(negedge clk);
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL basic_busy_drop got %b want 0", busy_o);
    end
    @(negedge clk);
    checks++;
    if (done_n - dn_base !== 1) begin
      errors++;
      $display("FAIL basic_done_pulses got %0d want 1",
               done_n - dn_base);
    end
    checks++;
    if (rq_n - rq_base !== e_n) begin
      errors++;
      $display("FAIL basic_req_count got %0d want %0d",
               rq_n - rq_base, e_n);
    end
    for (int k = 0; k < e_n; k++) begin
      checks++;
      if ({rq_cn[(rq_base + k) % 512], rq_nb[(rq_base + k) % 512],
           rq_bits[(rq_base + k) % 512]} !==
          {e_cn[k], e_nb[k], e_bits[k]}) begin
        errors++;
        $display("FAIL basic_req%0d got %h/%0d/%h want %h/%0d/%h", k,
                 rq_cn[(rq_base + k) % 512], rq_nb[(rq_base + k) % 512],
                 rq_bits[(rq_base + k) % 512], e_cn[k], e_nb[k], e_bits[k]);
      end
    end
    checks++;
    if ({rq_cn[(rq_base + 3) % 512], rq_nb[(rq_base + 3) % 512],
         rq_bits[(rq_base + 3) % 512]} !== {8'd51, 4'd5, 15'h1E}) begin
      errors++;
      $display("FAIL basic_last_req got %h want 33/5/001e",
               rq_bits[(rq_base + 3) % 512]);
    end
    checks++;
    if ({f_pops - f_base, i_pops - i_base} !== {32'd1, 32'd1}) begin
      errors++;
      $display("FAIL basic_pops got %0d/%0d want 1/1",
               f_pops - f_base, i_pops - i_base);
    end
  endtask

  task automatic test_stall();
    int held;
    bit tmo;
    logic [90:0] snap, cur;
    cfg1();
    prep(4, 1, 'hA5, 'h3C);
    req_ready_i = 1'b0;
    held = 0;
    tmo = 1'b1;
    snap = '0;
    @(negedge clk); start_i = 1'b1;
    @(negedge clk); start_i = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (done_o) begin
        tmo = 1'b0;
        break;
      end
      if (req_valid_o) begin
        cur = {carrier_num_o, nbits_o, bits_o,
               32'(f_pops), 32'(i_pops)};
        if (held == 0) begin
          snap = cur;
        end else begin
          checks++;
          if (cur !== snap) begin
            errors++;
            $display("FAIL stall_stable got %h want %h", cur, snap);
          end
        end
        if (held < 5) begin
          req_ready_i = 1'b0;
          held++;
        end else begin
          req_ready_i = 1'b1;
          held = 0;
        end
      end else begin
        req_ready_i = 1'b0;
      end
      @(negedge clk);
    end
    req_ready_i = 1'b1;
    checks++;
    if (tmo) begin
      errors++;
      $display("FAIL stall_timeout got no done want done");
    end
    checks++;
    if (rq_n - rq_base !== e_n) begin
      errors++;
      $display("FAIL stall_req_count got %0d want %0d",
               rq_n - rq_base, e_n);
    end
    for (int k = 0; k < e_n; k++) begin
      checks++;
      if ({rq_cn[(rq_base + k) % 512], rq_nb[(rq_base + k) % 512],
           rq_bits[(rq_base + k) % 512]} !==
          {e_cn[k], e_nb[k], e_bits[k]}) begin
        errors++;
        $display("FAIL stall_req%0d got %h want %h", k,
                 rq_bits[(rq_base + k) % 512], e_bits[k]);
      end
    end
    checks++;
    if ({f_pops - f_base, i_pops - i_base} !== {32'd1, 32'd1}) begin
      errors++;
      $display("FAIL stall_pops got %0d/%0d want 1/1",
               f_pops - f_base, i_pops - i_base);
    end
    @(negedge clk);
  endtask

  task automatic test_fast_wait();
    int cyc;
    bit tmo;
    cfg1();
    prep(4, 1, 'hA5, 'h3C);
    f_en = 1'b0;
    @(negedge clk); start_i = 1'b1;
    @(negedge clk); start_i = 1'b0;
    for (int c = 0; c < 10; c++) begin
      checks++;
      if ({fast_ready_o, inter_ready_o, req_valid_o} !== 3'b100) begin
        errors++;
        $display("FAIL fast_wait_c%0d got %b want 100", c,
                 {fast_ready_o, inter_ready_o, req_valid_o});
      end
      @(negedge clk);
    end
    f_en = 1'b1;
    run_sym(1'b0, 1'b0, cyc, tmo);
    checks++;
    if (tmo) begin
      errors++;
      $display("FAIL fast_wait_timeout got no done want done");
    end
    @(negedge clk);
    checks++;
    if (rq_n - rq_base !== e_n) begin
      errors++;
      $display("FAIL fast_wait_req_count got %0d want %0d",
               rq_n - rq_base, e_n);
    end
    for (int k = 0; k < e_n; k++) begin
      checks++;
      if ({rq_cn[(rq_base + k) % 512], rq_nb[(rq_base + k) % 512],
           rq_bits[(rq_base + k) % 512]} !==
          {e_cn[k], e_nb[k], e_bits[k]}) begin
        errors++;
        $display("FAIL fast_wait_req%0d got %h want %h", k,
                 rq_bits[(rq_base + k) % 512], e_bits[k]);
      end
    end
  endtask

  task automatic test_zero_used();
    int cyc;
    bit tmo;
    used_c_i = 9'd0;
    fast_bits_i = 16'd0;
    prep(0, 0, -1, -1);
    run_sym(1'b1, 1'b0, cyc, tmo);
    checks++;
    if (tmo || cyc !== 2) begin
      errors++;
      $display("FAIL zero_done_latency got %0d want 2", cyc);
    end
    @(negedge clk);
    checks++;
    if ({rq_n - rq_base, f_pops - f_base, i_pops - i_base,
         done_n - dn_base} !== {32'd0, 32'd0, 32'd0, 32'd1}) begin
      errors++;
      $display("FAIL zero_activity got req %0d pops %0d/%0d done %0d want 0 0/0 1",
               rq_n - rq_base, f_pops - f_base, i_pops - i_base,
               done_n - dn_base);
    end
  endtask

  task automatic test_bl0();
    int cyc;
    bit tmo;
    bl_tab[0] = 4'd0; cn_tab[0] = 8'd48;
    bl_tab[1] = 4'd8; cn_tab[1] = 8'd49;
    used_c_i = 9'd2;
    fast_bits_i = 16'd0;
    prep(2, 0, -1, 'hFF);
    run_sym(1'b1, 1'b0, cyc, tmo);
    @(negedge clk);
    checks++;
    if (tmo || rq_n - rq_base !== 2) begin
      errors++;
      $display("FAIL bl0_req_count got %0d want 2", rq_n - rq_base);
    end
    checks++;
    if ({rq_cn[rq_base % 512], rq_nb[rq_base % 512],
         rq_bits[rq_base % 512]} !== {8'd48, 4'd0, 15'h0}) begin
      errors++;
      $display("FAIL bl0_req0 got %h/%0d/%h want 30/0/0000",
               rq_cn[rq_base % 512], rq_nb[rq_base % 512],
               rq_bits[rq_base % 512]);
    end
    checks++;
    if ({rq_cn[(rq_base + 1) % 512], rq_nb[(rq_base + 1) % 512],
         rq_bits[(rq_base + 1) % 512]} !== {8'd49, 4'd8, 15'hFF}) begin
      errors++;
      $display("FAIL bl0_req1 got %h/%0d/%h want 31/8/00ff",
               rq_cn[(rq_base + 1) % 512], rq_nb[(rq_base + 1) % 512],
               rq_bits[(rq_base + 1) % 512]);
    end
    checks++;
    if ({f_pops - f_base, i_pops - i_base} !== {32'd0, 32'd1}) begin
      errors++;
      $display("FAIL bl0_pops got %0d/%0d want 0/1",
               f_pops - f_base, i_pops - i_base);
    end
  endtask

  task automatic test_random();
    int n, total, need, fb, cyc;
    bit tmo;
    for (int it = 0; it < 8; it++) begin
      n = $urandom_range(1, 24);
      total = 0;
      for (int k = 0; k < n; k++) begin
        bl_tab[k] = 4'($urandom_range(0, 15));
        cn_tab[k] = 8'($urandom);
        total += int'(bl_tab[k]);
      end
      need = (total + 7) / 8;
      fb = $urandom_range(0, need);
      used_c_i = 9'(n);
      fast_bits_i = 16'(fb * 8 + $urandom_range(0, 7));
      prep(n, fb, -1, -1);
      run_sym(1'b1, 1'b1, cyc, tmo);
      @(negedge clk);
      checks++;
      if (tmo || rq_n - rq_base !== e_n) begin
        errors++;
        $display("FAIL rand%0d_req_count got %0d want %0d", it,
                 rq_n - rq_base, e_n);
      end
      for (int k = 0; k < e_n; k++) begin
        checks++;
        if ({rq_cn[(rq_base + k) % 512], rq_nb[(rq_base + k) % 512],
             rq_bits[(rq_base + k) % 512]} !==
            {e_cn[k], e_nb[k], e_bits[k]}) begin
          errors++;
          $display("FAIL rand%0d_req%0d got %h/%0d/%h want %h/%0d/%h",
                   it, k, rq_cn[(rq_base + k) % 512],
                   rq_nb[(rq_base + k) % 512],
                   rq_bits[(rq_base + k) % 512],
                   e_cn[k], e_nb[k], e_bits[k]);
        end
      end
      checks++;
      if ({f_pops - f_base, i_pops - i_base} !== {e_fp, e_ip}) begin
        errors++;
        $display("FAIL rand%0d_pops got %0d/%0d want %0d/%0d", it,
                 f_pops - f_base, i_pops - i_base, e_fp, e_ip);
      end
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    bit tmo;
    logic [46:0] o;
    cfg1();
    prep(4, 1, 'hA5, 'h3C);
    i_en = 1'b0;
    @(negedge clk); start_i = 1'b1;
    @(negedge clk); start_i = 1'b0;
    for (int c = 0; c < 12; c++) @(negedge clk);
    checks++;
    if ({inter_ready_o, tbl_idx_o} !== {1'b1, 8'd2}) begin
      errors++;
      $display("FAIL rmid_stalled got %b/%0d want 1/2",
               inter_ready_o, tbl_idx_o);
    end
    #2 reset = 1'b1;
    #1;
    o = {busy_o, done_o, req_valid_o, fast_ready_o,
         inter_ready_o, tbl_idx_o, bits_o, nbits_o,
         carrier_num_o, 6'd0};
    checks++;
    if (o !== '0) begin
      errors++;
      $display("FAIL rmid_outputs got %h want 0", o);
    end
    @(negedge clk);
    reset = 1'b0;
    i_en = 1'b1;
    prep(4, 1, 'hA5, 'h3C);
    run_sym(1'b1, 1'b0, cyc, tmo);
    @(negedge clk);
    checks++;
    if (tmo || rq_n - rq_base !== 4 || done_n - dn_base !== 1) begin
      errors++;
      $display("FAIL rmid_counts got req %0d done %0d want 4 1",
               rq_n - rq_base, done_n - dn_base);
    end
    for (int k = 0; k < e_n; k++) begin
      checks++;
      if ({rq_cn[(rq_base + k) % 512], rq_nb[(rq_base + k) % 512],
           rq_bits[(rq_base + k) % 512]} !==
          {e_cn[k], e_nb[k], e_bits[k]}) begin
        errors++;
        $display("FAIL rmid_req%0d got %h want %h", k,
                 rq_bits[(rq_base + k) % 512], e_bits[k]);
      end
    end
    checks++;
    if ({f_pops - f_base, i_pops - i_base} !== {32'd1, 32'd1}) begin
      errors++;
      $display("FAIL rmid_pops got %0d/%0d want 1/1",
               f_pops - f_base, i_pops - i_base);
    end
  endtask

  initial begin
    reset = 1'b1;
    start_i = 1'b0;
    req_ready_i = 1'b1;
    used_c_i = '0;
    fast_bits_i = '0;
    for (int k = 0; k < 256; k++) begin
      bl_tab[k] = '0;
      cn_tab[k] = '0;
      f_mem[k] = '0;
      i_mem[k] = '0;
    end
    test_reset();
    test_basic();
    test_stall();
    test_fast_wait();
    test_zero_used();
    test_bl0();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
